// File: rtl/acc_add_sub_seq.sv
// Accumulate/subtract sequencer: takes a programmed number of 4-bit operands over
// valid/ready and folds each into a running accumulator with sticky carry/borrow.
module acc_add_sub_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] len_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_in,
    input  logic       mode,
    output logic [3:0] acc_out,
    output logic       carry_out,
    output logic       borrow_out,
    output logic [3:0] count_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_len;
    logic [DW-1:0] r_acc;
    logic          r_carry;
    logic          r_borrow;
    logic [DW-1:0] r_cnt;

    logic          w_accept;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_diff;
    logic          w_lt;
    logic [DW-1:0] w_cnt_inc;

    // Datapath terms; the accept qualifier uses registered state only
    assign w_accept  = in_valid & (r_state == S_RUN);
    assign w_sum     = {1'b0, r_acc} + {1'b0, a_in};
    assign w_diff    = r_acc - a_in;
    assign w_lt      = (r_acc < a_in);
    assign w_cnt_inc = r_cnt + DW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded handshake/status outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (len_in != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && (w_cnt_inc == r_len)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Results persist through IDLE until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_len    <= len_in;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (mode) begin
                r_acc    <= w_diff;
                r_borrow <= r_borrow | w_lt;
            end else begin
                r_acc    <= w_sum[DW-1:0];
                r_carry  <= r_carry | w_sum[DW];
            end
        end
    end

    assign acc_out    = r_acc;
    assign carry_out  = r_carry;
    assign borrow_out = r_borrow;
    assign count_out  = r_cnt;

endmodule
